// File: rtl/uart_axis_pkg.sv
// Shared definitions for the UART-RX to AXI4-Stream bridge.
//   DATA_BITS_DEF : default received byte width
//   ENTRY_W       : FIFO entry width for the default byte width ({last, data})
//   entry_w()     : FIFO entry width for an arbitrary byte width
//   level_w()     : width of an occupancy counter able to hold 0..depth
package uart_axis_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int ENTRY_W       = DATA_BITS_DEF + 1;

  function automatic int entry_w(input int data_bits);
    return data_bits + 1;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (accepted when not full, or when full with a pop)
//   pop      : remove the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry, valid whenever empty=0
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : occupancy, 0..DEPTH
// Handshake: an entry moves only on the clock edge where push (or pop) is
// high and the FIFO can honour it; the head is never altered by a push.
module uart_sync_fifo
  import uart_axis_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage has no reset: contents are only observable while level != 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// Buffers bytes from a UART receiver and presents them as an AXI4-Stream
// master, marking TLAST every PKT_LEN accepted bytes and accounting for
// bytes dropped because the FIFO was full.
//   clk, rst      : clock, asynchronous active-high reset
//   rx_data       : received byte
//   rx_valid      : one-cycle pulse qualifying rx_data
//   m_axis_tdata  : stream data (head of FIFO, 0 when idle)
//   m_axis_tvalid : stream valid (FIFO not empty)
//   m_axis_tready : consumer ready
//   m_axis_tlast  : end of packet
//   level         : FIFO occupancy
//   overflow      : sticky drop flag
//   drop_cnt      : saturating count of dropped bytes
//   clr_ovf       : one-cycle pulse clearing overflow and drop_cnt
// Handshake: a byte transfers on every edge where m_axis_tvalid and
// m_axis_tready are both high; while tvalid is high and tready low, tdata,
// tlast and tvalid hold. The receiver side cannot stall, so a byte arriving
// when the FIFO is full and nothing leaves is dropped.
module uart_rx_axis_bridge
  import uart_axis_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DEPTH     = 16,
  parameter int PKT_LEN   = 16,
  parameter int DROP_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_BITS-1:0]      rx_data,
  input  logic                      rx_valid,
  output logic [DATA_BITS-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  input  logic                      clr_ovf
);

  localparam int EW  = entry_w(DATA_BITS);
  localparam int PCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [PCW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [EW-1:0] head;
  logic [EW-1:0] wr_entry;
  logic          fifo_full, fifo_empty;
  logic          push, pop, drop, last;

  assign m_axis_tvalid = ~fifo_empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign push          = rx_valid & (~fifo_full | pop);
  assign drop          = rx_valid & fifo_full & ~pop;
  assign last          = (pkt_cnt_q == PCW'(PKT_LEN - 1));
  assign wr_entry      = {last, rx_data};

  // FIFO storage is unreset, so mask the head while idle to present zeros.
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_BITS];
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

  uart_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    // Only accepted bytes count toward packet boundaries.
    if (push) pkt_cnt_d = last ? '0 : pkt_cnt_q + PCW'(1);

    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    // A drop in the same cycle as a clear wins: the new drop is counted.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)                     drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Self-checking bench for uart_rx_axis_bridge (DEPTH=16, PKT_LEN=4).
module tb_uart_rx_axis_bridge;

  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int PKT_LEN   = 4;
  localparam int DROP_W    = 8;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DATA_BITS-1:0] rx_data = '0;
  logic                 rx_valid = 1'b0;
  logic                 m_axis_tready = 1'b0;
  logic                 clr_ovf = 1'b0;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [4:0]           level;
  logic                 overflow;
  logic [DROP_W-1:0]    drop_cnt;

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .PKT_LEN   (PKT_LEN),
    .DROP_W    (DROP_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .level         (level),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .clr_ovf       (clr_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q holds {last, data} of every byte the bridge should be holding.
  logic [DATA_BITS:0] exp_q[$];
  logic [DATA_BITS:0] got_q[$];
  int                 m_pkt  = 0;
  logic               m_ovf  = 1'b0;
  int                 m_drop = 0;
  logic               stall  = 1'b0;
  logic [DATA_BITS:0] stall_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pkt  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      stall  = 1'b0;
    end else begin
      bit pop;
      bit full;
      stall     = m_axis_tvalid && !m_axis_tready;
      stall_val = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      pop  = (exp_q.size() != 0) && m_axis_tready;
      full = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (rx_valid) begin
        if (!full || pop) begin
          exp_q.push_back({(m_pkt == PKT_LEN - 1), rx_data});
          m_pkt = (m_pkt + 1) % PKT_LEN;
        end else begin
          m_ovf  = 1'b1;
          m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("tvalid",   m_axis_tvalid, exp_q.size() != 0);
    check("level",    level,         exp_q.size());
    check("overflow", overflow,      m_ovf);
    check("drop_cnt", drop_cnt,      m_drop);
    if (exp_q.size() != 0) begin
      check("tdata", m_axis_tdata, exp_q[0][DATA_BITS-1:0]);
      check("tlast", m_axis_tlast, exp_q[0][DATA_BITS]);
    end
    if (rst) begin
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast", m_axis_tlast, 0);
    end
    if (stall && !rst)
      check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_val});
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for one cycle; returns at the next falling edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    rx_valid      = v;
    rx_data       = d;
    m_axis_tready = rdy;
    clr_ovf       = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid      = 1'b0;
    m_axis_tready = 1'b0;
    clr_ovf       = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_done", level, 0);
  endtask

  logic [8:0] t2_exp [8] = '{9'h001, 9'h002, 9'h003, 9'h104,
                              9'h005, 9'h006, 9'h007, 9'h108};

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_level",    level, 0);
    check("reset_tvalid",   m_axis_tvalid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_drop",     drop_cnt, 0);

    // 1: single byte, first-word fall-through latency
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t1_tvalid", m_axis_tvalid, 1);
    check("t1_tdata",  m_axis_tdata, 8'hA5);
    check("t1_tlast",  m_axis_tlast, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_level",  level, 0);
    check("t1_count",  got_q.size(), 1);
    check("t1_got",    got_q[0], 9'h0A5);

    // 2: packet marking every 4 bytes
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    drain();
    check("t2_count", got_q.size(), 8);
    for (int j = 0; j < 8; j++) check("t2_stream", got_q[j], t2_exp[j]);

    // 3: fill, overflow by three, drain; packet position ignores drops
    do_reset();
    for (int i = 0; i < 19; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("t3_level",    level, 16);
    check("t3_overflow", overflow, 1);
    check("t3_drop",     drop_cnt, 3);
    drain();
    check("t3_count", got_q.size(), 16);
    for (int j = 0; j < 16; j++) check("t3_stream", got_q[j], {(j % 4) == 3, 8'(j)});
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    drain();
    check("t3_next_first", got_q[0], 9'h040);
    check("t3_next_last",  got_q[3], 9'h143);

    // 4: full FIFO with simultaneous push and pop; then clear/drop interplay
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("t4_full_level", level, 16);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    check("t4_level_held", level, 16);
    check("t4_no_ovf",     overflow, 0);
    check("t4_new_head",   m_axis_tdata, 8'h51);
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b1, 8'h89, 1'b0, 1'b0);
    check("t4_drop2", drop_cnt, 2);
    drive(1'b1, 8'h8A, 1'b0, 1'b1);
    check("t4_clr_drop_ovf", overflow, 1);
    check("t4_clr_drop_cnt", drop_cnt, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_clr_ovf", overflow, 0);
    check("t4_clr_cnt", drop_cnt, 0);
    drain();
    check("t4_count", got_q.size(), 17);
    check("t4_first", got_q[0],  9'h050);
    check("t4_p4end", got_q[15], 9'h15F);
    check("t4_last",  got_q[16], 9'h077);

    // 5: random back-pressure, stream must match input order
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i), 1'($urandom_range(0, 3) != 0), 1'b0);
      drive(1'b0, 8'h00, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();
    check("t5_count", got_q.size(), 40);
    for (int j = 0; j < 40; j++) check("t5_stream", got_q[j], {(j % 4) == 3, 8'(j)});

    // 6: asynchronous reset mid-packet
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("t6_level5", level, 5);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tdata",  m_axis_tdata, 0);
    check("t6_rst_tlast",  m_axis_tlast, 0);
    check("t6_rst_level",  level, 0);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h33 + i), 1'b1, 1'b0);
    drain();
    check("t6_first", got_q[0], 9'h033);
    check("t6_last",  got_q[3], 9'h136);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_bridge.md
Name: uart_rx_axis_bridge

Overview:
- Sits directly downstream of the UART receiver.
- Takes its single-cycle received-byte pulse (rx_data/rx_valid) and buffers bytes in a synchronous FIFO.
- Presents the bytes as an AXI4-Stream master, with TLAST generated every PKT_LEN bytes.
- Reports overflow, since the receiver cannot be back-pressured.

Parameters:
DATA_BITS, 8, width of each received byte and of m_axis_tdata
DEPTH, 16, FIFO entries; power of two, >= 2
PKT_LEN, 16, bytes per AXIS packet; >= 1; TLAST is asserted on every PKT_LEN-th accepted byte
DROP_W, 8, width of the saturating dropped-byte counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  DATA_BITS  byte from the UART receiver
rx_valid  in  1  one-cycle pulse; rx_data is valid in this cycle
m_axis_tdata  out  DATA_BITS  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready from the consumer
m_axis_tlast  out  1  end of packet
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when a byte is dropped
drop_cnt  out  DROP_W  saturating count of dropped bytes
clr_ovf  in  1  one-cycle pulse; clears overflow and drop_cnt

Behaviour:
- Reset (asynchronous assert) takes effect immediately:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, level=0, overflow=0, drop_cnt=0.
  - Read/write pointers and pkt_cnt cleared.
  - Reset mid-packet discards all stored bytes; the next accepted byte starts a new packet.
- FIFO entry = {last, data}.
- Push:
  - Occurs when rx_valid=1 and the FIFO is not full.
  - Alternatively, when rx_valid=1, full=1 and a pop occurs in the same cycle. Full-with-pop accepts the byte and level is unchanged.
- Pop occurs when m_axis_tvalid && m_axis_tready.
- Packet marking:
  - pkt_cnt counts 0..PKT_LEN-1 and advances only on push.
  - The pushed entry's last = (pkt_cnt==PKT_LEN-1); pkt_cnt then wraps to 0.
  - PKT_LEN=1 gives last=1 on every byte.
- Drop:
  - Occurs when rx_valid=1, full=1 and there is no pop.
  - The byte is discarded; pkt_cnt does not advance.
  - overflow <= 1.
  - drop_cnt increments, saturating at 2^DROP_W-1.
- clr_ovf:
  - Clears overflow and drop_cnt.
  - If a drop occurs in the same cycle, set/increment wins: overflow=1, drop_cnt=1.
- Output (first-word fall-through):
  - m_axis_tvalid = (level!=0); tdata/tlast reflect the head entry.
  - Latency: a byte pushed at clock edge N produces tvalid=1 after edge N, visible in cycle N+1 when the FIFO was empty.
  - AXIS rule: once tvalid=1, tdata/tlast/tvalid stay stable until the handshake completes. Pushes never alter the head entry.
- level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows; a pop while empty is impossible because tvalid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- No state machine beyond the counters; no combinational path from rx_valid to m_axis_tvalid.

Decomposition:
- Package uart_axis_pkg holds:
  - DATA_BITS default
  - entry width localparam (DATA_BITS+1)
  - level width function
- Sub-module uart_sync_fifo:
  - Generic single-clock FWFT FIFO with push, pop, full, empty and level.
  - Instantiated once.
  - The bridge adds packet marking, drop accounting and AXIS mapping.

Test Plan:
1. Single byte 0xA5 pulsed, tready=1 -> tvalid=1 on the next cycle with tdata=0xA5 and tlast=0; pops the following edge; level returns to 0.
2. PKT_LEN=4, bytes 0x01..0x08, tready=1 -> tlast=1 exactly on 0x04 and 0x08, all bytes in order.
3. tready=0, push 16 bytes then 3 more -> level=16, overflow=1, drop_cnt=3. Drain yields 0x00..0x0F only, and the tlast position ignores the dropped bytes.
4. Full FIFO, rx_valid and a pop in the same cycle -> byte accepted, level stays 16, overflow stays 0.
5. Toggle tready randomly during 40 bytes -> tdata/tlast stay stable whenever tvalid && !tready; output sequence equals input.
6. Assert rst mid-packet with level=5, then push 0x33 -> outputs zero during reset; afterwards the first byte out is 0x33 with pkt_cnt restarted. clr_ovf concurrent with a drop leaves overflow=1, drop_cnt=1.
